rf_writeback_unit: RTL and testbench

- Writer-side companion to the pipeline register file. Accepts an in-order stream of completed instructions from the MEM stage, waits for data-memory responses on loads, and formats load data by size and sign.
- Drives the register file write port (regWrite/writeRegister/writeData) with registered, one-cycle write pulses.
- Exports a per-register pending-write mask for the hazard unit.

---
 rtl/rv_pkg.sv | 64 ++++++
 rtl/rf_writeback_unit_if.sv | 32 +++
 rtl/rf_wb_fifo.sv | 65 ++++++
 rtl/rf_writeback_unit.sv | 146 ++++++++++++++
 tb/tb_rf_writeback_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared types, widths and load formatting for the register-file writeback unit.
package rv_pkg;

  localparam int unsigned WORD_LEN   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    WAIT_LOAD
  } wb_state_e;

  typedef struct packed {
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_LEN-1:0]   data;
    logic [2:0]            funct3;
    logic [1:0]            addr_lo;
  } wb_entry_t;

  typedef struct packed {
    logic [WORD_LEN-1:0] data;
    logic                err;
  } ld_fmt_t;

  // Lane select plus sign/zero extension; misaligned or unknown codes flag err.
  function automatic ld_fmt_t format_load(input logic [WORD_LEN-1:0] raw,
                                          input logic [2:0]          funct3,
                                          input logic [1:0]          addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    ld_fmt_t     res;
    b        = 8'(raw >> {addr_lo, 3'b000});
    h        = 16'(raw >> {addr_lo[1], 4'b0000});
    res.data = '0;
    res.err  = 1'b0;
    case (funct3)
      F3_LB:  res.data = {{(WORD_LEN-8){b[7]}}, b};
      F3_LH: begin
        res.data = {{(WORD_LEN-16){h[15]}}, h};
        res.err  = addr_lo[0];
      end
      F3_LW: begin
        res.data = raw;
        res.err  = (addr_lo != 2'b00);
      end
      F3_LBU: res.data = {{(WORD_LEN-8){1'b0}}, b};
      F3_LHU: begin
        res.data = {{(WORD_LEN-16){1'b0}}, h};
        res.err  = addr_lo[0];
      end
      default: res.err = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rf_writeback_unit_if.sv
// MEM-stage input, data-memory response and register-file write port bundle.
interface rf_writeback_unit_if;
  import rv_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_is_load;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [WORD_LEN-1:0]   in_data;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;
  logic                  mem_rsp_valid;
  logic [WORD_LEN-1:0]   mem_rsp_data;
  logic                  regWrite;
  logic [REG_ADDR_W-1:0] writeRegister;
  logic [WORD_LEN-1:0]   writeData;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  err;

  modport master (
    output in_valid, in_is_load, in_rd, in_data, in_funct3, in_addr_lo,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready, regWrite, writeRegister, writeData, busy_mask, err
  );

  modport slave (
    input  in_valid, in_is_load, in_rd, in_data, in_funct3, in_addr_lo,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready, regWrite, writeRegister, writeData, busy_mask, err
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Generic synchronous FIFO exposing its storage and per-slot valid bits.
module rf_wb_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [Width-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [Width-1:0]            head_o,
  output logic [$clog2(Depth):0]      count_o,
  output logic [Depth-1:0][Width-1:0] mem_o,
  output logic [Depth-1:0]            valid_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [Depth-1:0]            valid_q, valid_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q]   = push_data_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign mem_o   = mem_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/rf_writeback_unit.sv
// In-order writeback: queues MEM-stage results, waits on load responses and
// drives one-cycle register-file write pulses plus a pending-write mask.
module rf_writeback_unit
  import rv_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                clk,
  input  logic                rst,
  rf_writeback_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(Depth) + 1;
  localparam int unsigned EW = $bits(wb_entry_t);

  wb_state_e             state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [WORD_LEN-1:0]   wr_data_q, wr_data_d;
  logic                  err_q, err_d;
  logic                  rsp_drop_q, rsp_drop_d;

  logic                  push;
  logic                  pop;
  logic                  rsp_expected;
  logic [CW-1:0]         count;
  wb_entry_t             head;
  wb_entry_t             new_entry;
  wb_entry_t [Depth-1:0] slots;
  logic [Depth-1:0]      slot_valid;
  ld_fmt_t               fmt;
  logic [WORD_LEN-1:0]   ret_data;
  logic [NUM_REGS-1:0]   busy;

  assign bus.in_ready = (count < CW'(Depth));
  assign push         = bus.in_valid && bus.in_ready;

  always_comb begin
    new_entry.is_load = bus.in_is_load;
    new_entry.rd      = bus.in_rd;
    new_entry.data    = bus.in_data;
    new_entry.funct3  = bus.in_funct3;
    new_entry.addr_lo = bus.in_addr_lo;
  end

  rf_wb_fifo #(
    .Width (EW),
    .Depth (Depth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (new_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .mem_o       (slots),
    .valid_o     (slot_valid)
  );

  assign fmt          = format_load(bus.mem_rsp_data, head.funct3, head.addr_lo);
  assign rsp_expected = (state_q != IDLE) && head.is_load;

  // Next state and write-port values; the head entry retires on pop.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    wr_en_d    = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    rsp_drop_d = 1'b0;
    ret_data   = head.data;

    case (state_q)
      IDLE: begin
        if (push) state_d = HEAD;
      end
      HEAD: begin
        if (!head.is_load) begin
          pop = 1'b1;
        end else if (bus.mem_rsp_valid) begin
          pop      = 1'b1;
          ret_data = fmt.data;
          err_d    = err_q | fmt.err;
        end else begin
          state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (bus.mem_rsp_valid) begin
          pop      = 1'b1;
          ret_data = fmt.data;
          err_d    = err_q | fmt.err;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response right after reset belongs to a discarded load.
    if (bus.mem_rsp_valid && !rsp_expected && !rsp_drop_q) err_d = 1'b1;

    if (pop) begin
      state_d = ((count > CW'(1)) || push) ? HEAD : IDLE;
      if (head.rd != '0) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = head.rd;
        wr_data_d = ret_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      rsp_drop_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      rsp_drop_q <= rsp_drop_d;
    end
  end

  // Pending destinations of everything still queued; x0 never reads as busy.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (slot_valid[i]) busy[slots[i].rd] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign bus.regWrite      = wr_en_q;
  assign bus.writeRegister = wr_reg_q;
  assign bus.writeData     = wr_data_q;
  assign bus.busy_mask     = busy;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed and random stimulus against a queue-based retirement model.
module tb_rf_writeback_unit;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_writeback_unit_if bus ();

  rf_writeback_unit #(.Depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  alo;
  } ref_ent_t;

  ref_ent_t    mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_reg  = '0;
  logic [31:0] m_data = '0;
  logic        m_err  = 1'b0;
  logic        m_drop = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Returns {err, data} computed from byte/halfword arithmetic.
  function automatic logic [32:0] ref_load(input logic [31:0] raw, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] b, h, d;
    logic        e;
    b = (raw >> (8 * a)) & 32'hFF;
    h = (raw >> (16 * (a / 2))) & 32'hFFFF;
    d = '0;
    e = 1'b0;
    case (f3)
      3'd0: d = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1: begin d = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h; e = (a % 2) != 0; end
      3'd2: begin d = raw; e = (a != 0); end
      3'd4: d = b;
      3'd5: begin d = h; e = (a % 2) != 0; end
      default: e = 1'b1;
    endcase
    return {e, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One edge of the model: the head present before the edge may retire.
  task automatic model_edge(input logic r, input logic v, input logic ld, input logic [4:0] rd,
                            input logic [31:0] d, input logic [2:0] f3, input logic [1:0] alo,
                            input logic rv, input logic [31:0] rdat);
    ref_enst_dummy_t_guard: begin end
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0; m_err = 1'b0; m_drop = 1'b1;
    end else begin
      logic        can_push;
      logic        head_load;
      logic [32:0] fr;
      ref_ent_t    h;
      ref_ent_t    n;
      can_push  = v && (mq.size() < DEPTH);
      head_load = (mq.size() > 0) && mq[0].is_load;
      m_we      = 1'b0;
      if (mq.size() > 0 && (!mq[0].is_load || rv)) begin
        h = mq.pop_front();
        if (h.is_load) begin
          fr    = ref_load(rdat, h.f3, h.alo);
          m_err = m_err | fr[32];
        end else begin
          fr = {1'b0, h.data};
        end
        if (h.rd != 0) begin
          m_we = 1'b1; m_reg = h.rd; m_data = fr[31:0];
        end
      end
      if (rv && !head_load && !m_drop) m_err = 1'b1;
      if (can_push) begin
        n.is_load = ld; n.rd = rd; n.data = d; n.f3 = f3; n.alo = alo;
        mq.push_back(n);
      end
      m_drop = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic ld, input logic [4:0] rd,
                      input logic [31:0] d, input logic [2:0] f3, input logic [1:0] alo,
                      input logic rv, input logic [31:0] rdat);
    logic [31:0] exp_busy;
    rst = r;
    bus.in_valid = v; bus.in_is_load = ld; bus.in_rd = rd; bus.in_data = d;
    bus.in_funct3 = f3; bus.in_addr_lo = alo;
    bus.mem_rsp_valid = rv; bus.mem_rsp_data = rdat;
    @(posedge clk);
    model_edge(r, v, ld, rd, d, f3, alo, rv, rdat);
    #1;
    exp_busy = '0;
    foreach (mq[i]) exp_busy[mq[i].rd] = 1'b1;
    exp_busy[0] = 1'b0;
    chk("regWrite", 32'(bus.regWrite), 32'(m_we));
    chk("writeRegister", 32'(bus.writeRegister), 32'(m_reg));
    chk("writeData", bus.writeData, m_data);
    chk("err", 32'(bus.err), 32'(m_err));
    chk("busy_mask", bus.busy_mask, exp_busy);
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, rd, d, 3'd0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
    step(1'b0, 1'b1, 1'b1, rd, 32'hDEAD_BEEF, f3, alo, 1'b0, 32'd0);
  endtask

  task automatic rsp(input logic [31:0] rdat);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, rdat);
  endtask

  initial begin
    logic [2:0] f3_tab [5];
    f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW;
    f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;

    do_reset();
    do_reset();

    alu(5'd5, 32'h0000_00AA);
    idle(3);

    for (int i = 1; i <= 4; i++) alu(5'(i), 32'h100 + 32'(i));
    idle(5);

    // Blocked load at the head fills the queue; rd 9 is refused while full.
    load(5'd7, F3_LW, 2'd0);
    alu(5'd1, 32'h11);
    alu(5'd2, 32'h22);
    alu(5'd3, 32'h33);
    alu(5'd9, 32'h99);
    idle(1);
    rsp(32'h1122_3344);
    idle(4);

    load(5'd6, F3_LB, 2'd3);
    alu(5'd6, 32'd7);
    idle(5);
    rsp(32'h8012_3456);
    idle(3);

    load(5'd8, F3_LHU, 2'd2);
    rsp(32'h8001_0000);
    idle(2);

    load(5'd9, F3_LH, 2'd1);
    idle(1);
    rsp(32'h1234_5678);
    idle(3);

    do_reset();
    alu(5'd0, 32'h1234);
    idle(2);
    rsp(32'hCAFE_F00D);
    idle(2);

    // Reset while waiting on a load with three entries queued.
    do_reset();
    load(5'd10, F3_LW, 2'd0);
    alu(5'd11, 32'hB);
    alu(5'd12, 32'hC);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'h5555_5555);
    rsp(32'h6666_6666);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [2:0] f3;
      r  = ($urandom_range(0, 39) == 0);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : f3_tab[$urandom_range(0, 4)];
      step(r, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, f3,
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0,
           ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
